// File: rtl/hmac_block_loader.sv
// Word-serial loader in front of the HMAC-384 core: assembles a 1024-bit block, issues init/next, captures the tag.
// Optional feature macro: HMAC_BLOCK_LOADER_BYTESWAP_EN byte-reverses every accepted word before storage.
module hmac_block_loader #(
    parameter int BLOCK_BITS = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  zeroize,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [31:0]           s_data,
    input  logic                  s_first,
    input  logic                  core_ready,
    input  logic                  core_tag_valid,
    input  logic [383:0]          core_tag,
    output logic                  init_cmd,
    output logic                  next_cmd,
    output logic [BLOCK_BITS-1:0] block_msg,
    output logic [383:0]          tag_o,
    output logic                  tag_valid_o,
    output logic                  restart_err
);
    localparam int WORDS = BLOCK_BITS / 32;
    localparam int CNT_W = $clog2(WORDS);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_WAIT = 2'd1,
        S_CMD  = 2'd2,
        S_BUSY = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      wcnt_q, wcnt_d;
    logic                  first_q, first_d;
    logic [BLOCK_BITS-1:0] block_q, block_d;
    logic [383:0]          tag_q, tag_d;
    logic                  tag_valid_q, tag_valid_d;
    logic                  init_q, init_d;
    logic                  next_q, next_d;
    logic                  rerr_q, rerr_d;
    logic                  accept;
    logic                  restart;
    logic                  last_word;
    logic [CNT_W-1:0]      slot;
    logic [31:0]           word;

    function automatic logic [31:0] store_fmt(input logic [31:0] d);
`ifdef HMAC_BLOCK_LOADER_BYTESWAP_EN
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
        return d;
`endif
    endfunction

    // A word flagged s_first always becomes word 0, even mid-block.
    assign accept    = s_valid & s_ready;
    assign restart   = s_first & (wcnt_q != '0);
    assign last_word = ~s_first & (wcnt_q == LAST_WORD);
    assign slot      = s_first ? '0 : wcnt_q;
    assign word      = store_fmt(s_data);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FILL:  if (accept && last_word) state_d = S_WAIT;
            S_WAIT:  if (core_ready) state_d = S_CMD;
            S_CMD:   state_d = S_BUSY;
            S_BUSY:  if (core_tag_valid) state_d = S_FILL;
            default: state_d = S_FILL;
        endcase
        if (zeroize) state_d = S_FILL;
    end

    // Commands are registered on the WAIT->CMD edge so the pulse coincides with the CMD cycle.
    always_comb begin
        s_ready = (state_q == S_FILL);
        init_d  = 1'b0;
        next_d  = 1'b0;
        if (state_q == S_WAIT && core_ready && !zeroize) begin
            init_d = first_q;
            next_d = ~first_q;
        end
    end

    always_comb begin
        wcnt_d      = wcnt_q;
        first_d     = first_q;
        block_d     = block_q;
        tag_d       = tag_q;
        tag_valid_d = tag_valid_q;
        rerr_d      = 1'b0;
        if (accept) begin
            for (int i = 0; i < WORDS; i++) begin
                if (slot == CNT_W'(i)) block_d[BLOCK_BITS-1-32*i -: 32] = word;
            end
            if (s_first) begin
                wcnt_d  = CNT_W'(1);
                first_d = 1'b1;
                rerr_d  = restart;
            end else begin
                wcnt_d = last_word ? '0 : wcnt_q + 1'b1;
            end
        end
        if (state_q == S_WAIT && core_ready) tag_valid_d = 1'b0;
        if (state_q == S_CMD) first_d = 1'b0;
        if (state_q == S_BUSY && core_tag_valid) begin
            tag_d       = core_tag;
            tag_valid_d = 1'b1;
        end
        if (zeroize) begin
            wcnt_d      = '0;
            first_d     = 1'b1;
            block_d     = '0;
            tag_d       = '0;
            tag_valid_d = 1'b0;
            rerr_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wcnt_q      <= '0;
            first_q     <= 1'b1;
            block_q     <= '0;
            tag_q       <= '0;
            tag_valid_q <= 1'b0;
            init_q      <= 1'b0;
            next_q      <= 1'b0;
            rerr_q      <= 1'b0;
        end else begin
            wcnt_q      <= wcnt_d;
            first_q     <= first_d;
            block_q     <= block_d;
            tag_q       <= tag_d;
            tag_valid_q <= tag_valid_d;
            init_q      <= init_d;
            next_q      <= next_d;
            rerr_q      <= rerr_d;
        end
    end

    assign init_cmd    = init_q;
    assign next_cmd    = next_q;
    assign block_msg   = block_q;
    assign tag_o       = tag_q;
    assign tag_valid_o = tag_valid_q;
    assign restart_err = rerr_q;

endmodule

// File: tb/tb_hmac_block_loader.sv
// Scoreboard bench for hmac_block_loader: randomized word streams against a queue-based block model.
`timescale 1ns/1ps
module tb_hmac_block_loader;
    localparam int BB = 1024;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          zeroize = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [31:0]   s_data = '0;
    logic          s_first = 1'b0;
    logic          core_ready = 1'b1;
    logic          core_tag_valid = 1'b0;
    logic [383:0]  core_tag = '0;
    logic          init_cmd;
    logic          next_cmd;
    logic [BB-1:0] block_msg;
    logic [383:0]  tag_o;
    logic          tag_valid_o;
    logic          restart_err;

    hmac_block_loader #(.BLOCK_BITS(BB)) dut (
        .clk(clk), .reset(reset), .zeroize(zeroize),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_first(s_first),
        .core_ready(core_ready), .core_tag_valid(core_tag_valid), .core_tag(core_tag),
        .init_cmd(init_cmd), .next_cmd(next_cmd), .block_msg(block_msg),
        .tag_o(tag_o), .tag_valid_o(tag_valid_o), .restart_err(restart_err)
    );

    always #5 clk = ~clk;

    typedef struct { bit is_init; logic [BB-1:0] blk; int cyc; } cmd_t;
    typedef struct { logic [383:0] tag; int cyc; } tag_t;
    typedef struct { logic [31:0] d; bit f; } stim_t;

    cmd_t          cmd_q[$];
    tag_t          tag_q[$];
    int            rerr_q[$];
    stim_t         stim[$];
    logic [31:0]   words[$];
    int            n_cmp = 0;
    int            n_fail = 0;
    int            cyc = 0;
    bit            exp_init = 1'b1;
    bit            expect_busy = 1'b0;
    bit            pend_init;
    logic [BB-1:0] pend_blk = '0;
    logic          tv_prev = 1'b0;
    cmd_t          mon_e;
    tag_t          mon_t;
    int            mon_r;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_tag(input string name, input logic [383:0] act, input logic [383:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_blk(input string name, input logic [BB-1:0] act, input logic [BB-1:0] exp);
        int w;
        logic [31:0] aw, ew;
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            w = -1; aw = '0; ew = '0;
            for (int i = 0; i < 32; i++) begin
                if (w < 0 && act[BB-1-32*i -: 32] !== exp[BB-1-32*i -: 32]) begin
                    w = i; aw = act[BB-1-32*i -: 32]; ew = exp[BB-1-32*i -: 32];
                end
            end
            $display("FAIL %s: word %0d got %08h expected %08h", name, w, aw, ew);
        end
    endtask

    function automatic logic [31:0] xform(input logic [31:0] d);
`ifdef HMAC_BLOCK_LOADER_BYTESWAP_EN
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
        return d;
`endif
    endfunction

    // Reference model: a word list per block; a flagged word restarts the list.
    task automatic model_accept(input logic [31:0] d, input bit first, output bit done);
        done = 1'b0;
        if (first) begin
            if (words.size() != 0) rerr_q.push_back(cyc);
            words.delete();
            exp_init = 1'b1;
        end
        words.push_back(xform(d));
        if (words.size() == 32) begin
            pend_blk = '0;
            foreach (words[i]) pend_blk = {pend_blk[BB-33:0], words[i]};
            pend_init = exp_init;
            words.delete();
            done = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (init_cmd || next_cmd) begin
                check("cmd_exclusive", 64'(init_cmd & next_cmd), 64'(0));
                check("cmd_expected", 64'(cmd_q.size() != 0), 64'(1));
                if (cmd_q.size() != 0) begin
                    mon_e = cmd_q.pop_front();
                    check("cmd_init", 64'(init_cmd), 64'(mon_e.is_init));
                    check("cmd_next", 64'(next_cmd), 64'(!mon_e.is_init));
                    check("cmd_cycle", 64'(cyc), 64'(mon_e.cyc));
                    check("cmd_tag_valid_cleared", 64'(tag_valid_o), 64'(0));
                    check_blk("cmd_block", block_msg, mon_e.blk);
                end
            end
            if (restart_err) begin
                check("rerr_expected", 64'(rerr_q.size() != 0), 64'(1));
                if (rerr_q.size() != 0) begin
                    mon_r = rerr_q.pop_front();
                    check("rerr_cycle", 64'(cyc), 64'(mon_r));
                end
            end
            if (tag_valid_o && !tv_prev) begin
                check("tag_expected", 64'(tag_q.size() != 0), 64'(1));
                if (tag_q.size() != 0) begin
                    mon_t = tag_q.pop_front();
                    check_tag("tag_value", tag_o, mon_t.tag);
                    check("tag_cycle", 64'(cyc), 64'(mon_t.cyc));
                end
            end
            check("s_ready", 64'(s_ready), 64'(!expect_busy));
            if (expect_busy) check_blk("block_stable", block_msg, pend_blk);
        end
        tv_prev = tag_valid_o;
    end

    task automatic send_word(input logic [31:0] d, input bit first, input bit gappy, output bit done);
        int gap;
        bit rdy;
        done = 1'b0;
        rdy = 1'b0;
        gap = (gappy && ($urandom_range(0, 3) == 0)) ? $urandom_range(1, 3) : 0;
        repeat (gap) begin
            s_data = $urandom; s_first = 1'($urandom);
            @(posedge clk); #1;
        end
        s_valid = 1'b1; s_data = d; s_first = first;
        for (int k = 0; k < 64 && !rdy; k++) begin
            @(negedge clk);
            rdy = s_ready;
        end
        check("word_accepted", 64'(rdy), 64'(1));
        if (rdy) begin
            @(posedge clk); #1;
        end
        s_valid = 1'b0; s_first = 1'b0;
        if (rdy) model_accept(d, first, done);
    endtask

    task automatic finish_block(input int busy, input bit stale, input bit zero_busy, input logic [383:0] tagv);
        int c;
        cmd_t e;
        tag_t t;
        expect_busy = 1'b1;
        if (stale) begin
            core_tag_valid = 1'b1; core_tag = {12{$urandom}};
        end
        if (busy > 0) begin
            repeat (busy) begin @(posedge clk); #1; end
            core_ready = 1'b1;
        end
        c = cyc + 1;
        e.is_init = pend_init; e.blk = pend_blk; e.cyc = c;
        cmd_q.push_back(e);
        exp_init = 1'b0;
        while (cyc < c) begin @(posedge clk); #1; end
        @(posedge clk); #1;
        core_tag_valid = 1'b0;
        if (zero_busy) begin
            zeroize = 1'b1; core_tag_valid = 1'b1; core_tag = tagv;
            @(posedge clk); #1;
            zeroize = 1'b0; core_tag_valid = 1'b0; expect_busy = 1'b0;
            words.delete(); exp_init = 1'b1;
            check("zero_s_ready", 64'(s_ready), 64'(1));
            check("zero_tag_valid", 64'(tag_valid_o), 64'(0));
            check("zero_pulses", 64'({init_cmd, next_cmd, restart_err}), 64'(0));
            check_tag("zero_tag", tag_o, '0);
            check_blk("zero_block", block_msg, '0);
        end else begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            core_tag = tagv; core_tag_valid = 1'b1;
            t.tag = tagv; t.cyc = cyc + 1;
            tag_q.push_back(t);
            @(posedge clk); #1;
            core_tag_valid = 1'b0; expect_busy = 1'b0;
        end
    endtask

    task automatic run_block(input int busy, input bit gappy, input bit stale, input bit zero_busy,
                             input logic [383:0] tagv);
        bit done;
        done = 1'b0;
        core_ready = (busy == 0);
        foreach (stim[i]) if (!done) send_word(stim[i].d, stim[i].f, gappy, done);
        if (done) finish_block(busy, stale, zero_busy, tagv);
    endtask

    task automatic gen_block(input bit first0, input bit restarts);
        int cnt;
        stim_t s;
        cnt = 0;
        stim.delete();
        while (cnt < 32) begin
            s.d = $urandom;
            s.f = (stim.size() == 0) ? first0 : (restarts && $urandom_range(0, 39) == 0);
            if (s.f) cnt = 1; else cnt++;
            stim.push_back(s);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        bit done;
        logic [31:0] exp_w0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready", 64'(s_ready), 64'(1));
        check("rst_cmds", 64'({init_cmd, next_cmd, restart_err}), 64'(0));
        check("rst_tag_valid", 64'(tag_valid_o), 64'(0));
        check_tag("rst_tag", tag_o, '0);
        check_blk("rst_block", block_msg, '0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;

        // Single block with counting data, then an A5 tag.
        stim.delete();
        for (int i = 0; i < 32; i++) begin
            s.d = i; s.f = (i == 0);
            stim.push_back(s);
        end
        run_block(0, 1'b0, 1'b0, 1'b0, {48{8'hA5}});

        // Continuation block.
        gen_block(1'b0, 1'b0);
        run_block(0, 1'b0, 1'b0, 1'b0, {12{$urandom}});

        // Core busy for 10 cycles after fill.
        gen_block(1'b0, 1'b0);
        run_block(10, 1'b1, 1'b1, 1'b0, {12{$urandom}});

        // Mid-block restart after 5 words.
        stim.delete();
        for (int i = 0; i < 37; i++) begin
            s.d = (i == 5) ? 32'hDEADBEEF : $urandom;
            s.f = (i == 5);
            stim.push_back(s);
        end
        run_block(0, 1'b0, 1'b0, 1'b0, {12{$urandom}});

        // Byte order of word 0.
`ifdef HMAC_BLOCK_LOADER_BYTESWAP_EN
        exp_w0 = 32'h44332211;
`else
        exp_w0 = 32'h11223344;
`endif
        core_ready = 1'b1;
        send_word(32'h11223344, 1'b1, 1'b0, done);
        check("byte_order_word0", 64'(block_msg[BB-1 -: 32]), 64'(exp_w0));
        for (int i = 1; i < 32; i++) send_word($urandom, 1'b0, 1'b0, done);
        if (done) finish_block(0, 1'b0, 1'b0, {12{$urandom}});

        // Zeroize in BUSY with a same-cycle tag, then a block without s_first.
        gen_block(1'b1, 1'b0);
        run_block(0, 1'b0, 1'b0, 1'b1, {12{$urandom}});
        gen_block(1'b0, 1'b0);
        run_block(0, 1'b0, 1'b0, 1'b0, {12{$urandom}});

        // Randomized traffic.
        for (int n = 0; n < 8; n++) begin
            gen_block(1'($urandom), 1'b1);
            run_block($urandom_range(0, 3), 1'b1, 1'($urandom), 1'b0, {12{$urandom}});
        end

        // Asynchronous reset in the middle of a fill.
        for (int i = 0; i < 7; i++) send_word($urandom, (i == 0), 1'b0, done);
        #2 reset = 1'b1;
        #1;
        check_blk("async_rst_block", block_msg, '0);
        check("async_rst_s_ready", 64'(s_ready), 64'(1));
        check_tag("async_rst_tag", tag_o, '0);
        words.delete(); exp_init = 1'b1; expect_busy = 1'b0;
        @(negedge clk); #2 reset = 1'b0;
        @(posedge clk); #1;
        gen_block(1'b0, 1'b0);
        run_block(0, 1'b0, 1'b0, 1'b0, {12{$urandom}});

        repeat (4) @(posedge clk);
        #1;
        check("cmd_queue_drained", 64'(cmd_q.size()), 64'(0));
        check("tag_queue_drained", 64'(tag_q.size()), 64'(0));
        check("rerr_queue_drained", 64'(rerr_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
